ram_read_sequencer: RTL and testbench

Command-driven controller that sequences one ram_reader instance. It accepts a playback command (byte count, repeat count) and converts the byte count to full_blocks / partial_block_cycles. It then pulses start and waits for the reader to go idle, replaying the same region the requested number of times. It sits between the host-side control logic and the ram_reader, which owns the AR/R channels.

---
 rtl/ram_read_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ram_read_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_sequencer.sv
// Command-driven playback controller for a single ram_reader: converts a byte
// count into block/partial-cycle counts and replays the region N times.
module ram_read_sequencer #(
    parameter int DW           = 512,
    parameter int BLOCK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] cmd_bytes,
    input  logic [15:0] cmd_repeat,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        abort,
    output logic [31:0] full_blocks,
    output logic [7:0]  partial_block_cycles,
    output logic        start,
    input  logic        reader_idle,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] pass_count,
    output logic [31:0] cmd_count
);

    // state  | meaning
    // IDLE   | waiting for a command; cmd_ready=1
    // LOAD   | block counts settle; zero-length or aborted commands skip to FINISH
    // START  | one-cycle start pulse to the reader
    // WAIT   | waiting for the reader to return idle after a pass
    // FINISH | one-cycle done pulse, cmd_count advances

    localparam int          BPC_LOG2  = $clog2(DW / 8);
    localparam int          BLK_LOG2  = $clog2(BLOCK_CYCLES);
    localparam logic [31:0] BYTE_MASK = 32'((DW / 8) - 1);
    localparam logic [31:0] BLK_MASK  = 32'(BLOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cmd_cycles;
    logic        zero_q;
    logic [15:0] repeat_target_q;
    logic        abort_q;
    logic        first_wait_q;
    logic        accept;
    logic        abort_any;
    logic        pass_inc;
    logic        set_aborted;

    assign cmd_cycles = (cmd_bytes >> BPC_LOG2) + {31'd0, |(cmd_bytes & BYTE_MASK)};
    assign accept     = (state_q == IDLE) && cmd_valid;
    assign abort_any  = abort_q | abort;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        pass_inc    = 1'b0;
        set_aborted = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) state_d = LOAD;
            end
            LOAD: begin
                if (abort_any) begin
                    set_aborted = 1'b1;
                    state_d     = FINISH;
                end else if (zero_q) begin
                    state_d = FINISH;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                // A fresh abort here means no pass has been launched yet for this slot.
                if (abort_any) begin
                    set_aborted = 1'b1;
                    state_d     = FINISH;
                end else begin
                    start   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The reader still shows idle on the cycle it sees start, so skip it.
                if (!first_wait_q && reader_idle) begin
                    pass_inc = 1'b1;
                    if (abort_any) begin
                        set_aborted = 1'b1;
                        state_d     = FINISH;
                    end else if (({1'b0, pass_count} + 17'd1) < {1'b0, repeat_target_q}) begin
                        state_d = START;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_blocks          <= 32'd0;
            partial_block_cycles <= 8'd0;
            zero_q               <= 1'b0;
            repeat_target_q      <= 16'd0;
        end else if (accept) begin
            full_blocks          <= cmd_cycles >> BLK_LOG2;
            partial_block_cycles <= 8'(cmd_cycles & BLK_MASK);
            zero_q               <= (cmd_cycles == 32'd0);
            repeat_target_q      <= (cmd_repeat == 16'd0) ? 16'd1 : cmd_repeat;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            abort_q      <= 1'b0;
            first_wait_q <= 1'b0;
            aborted      <= 1'b0;
            pass_count   <= 16'd0;
            cmd_count    <= 32'd0;
        end else begin
            first_wait_q <= (state_q == START);
            if (accept) begin
                abort_q    <= 1'b0;
                aborted    <= 1'b0;
                pass_count <= 16'd0;
            end else begin
                if (state_q != IDLE && abort) abort_q <= 1'b1;
                if (set_aborted) aborted <= 1'b1;
                if (pass_inc && pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
            end
            if (state_q == FINISH) cmd_count <= cmd_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_ram_read_sequencer.sv
// Directed bench for ram_read_sequencer with a simple reader model that drops
// idle for a fixed number of cycles after each start pulse.
module tb_ram_read_sequencer;

    localparam int READ_DELAY = 100;

    logic        clk;
    logic        resetn;
    logic [31:0] cmd_bytes;
    logic [15:0] cmd_repeat;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        abort;
    logic [31:0] full_blocks;
    logic [7:0]  partial_block_cycles;
    logic        start;
    logic        reader_idle;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] pass_count;
    logic [31:0] cmd_count;

    int checks = 0;
    int errors = 0;
    int exp_cmds = 0;

    ram_read_sequencer #(.DW(512), .BLOCK_CYCLES(64)) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .cmd_bytes            (cmd_bytes),
        .cmd_repeat           (cmd_repeat),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .abort                (abort),
        .full_blocks          (full_blocks),
        .partial_block_cycles (partial_block_cycles),
        .start                (start),
        .reader_idle          (reader_idle),
        .busy                 (busy),
        .done                 (done),
        .aborted              (aborted),
        .pass_count           (pass_count),
        .cmd_count            (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reader model
    int rd_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reader_idle <= 1'b1;
            rd_cnt      <= 0;
        end else if (start) begin
            reader_idle <= 1'b0;
            rd_cnt      <= READ_DELAY;
        end else if (rd_cnt > 1) begin
            rd_cnt <= rd_cnt - 1;
        end else if (rd_cnt == 1) begin
            rd_cnt      <= 0;
            reader_idle <= 1'b1;
        end
    end

    // Monitor: start/done counts and distance from idle rising to each start
    int start_cnt = 0;
    int done_cnt  = 0;
    int cyc       = 0;
    int rise_cyc  = 0;
    logic idle_prev = 1'b1;
    int gaps [16];
    always @(posedge clk) begin
        if (reader_idle && !idle_prev) rise_cyc = cyc;
        idle_prev = reader_idle;
        if (start) begin
            gaps[start_cnt & 15] = cyc - rise_cyc;
            start_cnt++;
        end
        if (done) done_cnt++;
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] b, input logic [15:0] r);
        cmd_bytes  = b;
        cmd_repeat = r;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    // Single-pass command: checks block split, start at T+2, completion
    task automatic run_one(input logic [31:0] b, input logic [31:0] efull,
                           input logic [7:0] epart, input string tag);
        int s0, d0;
        s0 = start_cnt;
        d0 = done_cnt;
        issue(b, 16'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_full"}, full_blocks, efull);
        chk({tag, "_part"}, {24'd0, partial_block_cycles}, {24'd0, epart});
        @(negedge clk);
        chk({tag, "_start_t2"}, {31'd0, start}, 32'd1);
        wait_done(READ_DELAY + 50, {tag, "_done"});
        @(negedge clk);
        exp_cmds++;
        chk({tag, "_starts"}, 32'(start_cnt - s0), 32'd1);
        chk({tag, "_dones"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_pass"}, {16'd0, pass_count}, 32'd1);
        chk({tag, "_cmdcnt"}, cmd_count, 32'(exp_cmds));
        chk({tag, "_aborted"}, {31'd0, aborted}, 32'd0);
    endtask

    initial begin
        int s0, d0, n;
        resetn     = 1'b0;
        cmd_bytes  = 32'd0;
        cmd_repeat = 16'd0;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_aborted", {31'd0, aborted}, 32'd0);
        chk("rst_pass", {16'd0, pass_count}, 32'd0);
        chk("rst_cmdcnt", cmd_count, 32'd0);
        chk("rst_full", full_blocks, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        resetn = 1'b1;
        @(negedge clk);

        run_one(32'd10000, 32'd2, 8'd29, "b10000");
        run_one(32'd8192, 32'd2, 8'd0, "b8192");
        run_one(32'd1, 32'd0, 8'd1, "b1");
        run_one(32'd65, 32'd0, 8'd2, "b65");

        // Three passes back to back
        s0 = start_cnt;
        d0 = done_cnt;
        issue(32'd4096, 16'd3);
        chk("rep3_full", full_blocks, 32'd1);
        chk("rep3_part", {24'd0, partial_block_cycles}, 32'd0);
        wait_done(4 * READ_DELAY, "rep3_done");
        @(negedge clk);
        exp_cmds++;
        chk("rep3_starts", 32'(start_cnt - s0), 32'd3);
        chk("rep3_gap2", 32'(gaps[(s0 + 1) & 15]), 32'd1);
        chk("rep3_gap3", 32'(gaps[(s0 + 2) & 15]), 32'd1);
        chk("rep3_pass", {16'd0, pass_count}, 32'd3);
        chk("rep3_dones", 32'(done_cnt - d0), 32'd1);
        chk("rep3_cmdcnt", cmd_count, 32'(exp_cmds));

        // Abort during the second of five passes
        s0 = start_cnt;
        d0 = done_cnt;
        issue(32'd4096, 16'd5);
        n = 0;
        while (start_cnt < s0 + 2 && n < 4 * READ_DELAY) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_pass2", 32'(start_cnt - s0), 32'd2);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_pass_running", {16'd0, pass_count}, 32'd1);
        wait_done(2 * READ_DELAY, "abort_done");
        @(negedge clk);
        exp_cmds++;
        repeat (5) @(negedge clk);
        chk("abort_starts", 32'(start_cnt - s0), 32'd2);
        chk("abort_pass", {16'd0, pass_count}, 32'd2);
        chk("abort_flag", {31'd0, aborted}, 32'd1);
        chk("abort_dones", 32'(done_cnt - d0), 32'd1);
        chk("abort_cmdcnt", cmd_count, 32'(exp_cmds));

        // Zero-byte command, then a command held valid through FINISH
        s0 = start_cnt;
        issue(32'd0, 16'd4);
        chk("zero_aborted_clr", {31'd0, aborted}, 32'd0);
        chk("zero_busy", {31'd0, busy}, 32'd1);
        chk("zero_part", {24'd0, partial_block_cycles}, 32'd0);
        @(negedge clk);
        chk("zero_done_t2", {31'd0, done}, 32'd1);
        chk("zero_no_start", {31'd0, start}, 32'd0);
        cmd_bytes  = 32'd64;
        cmd_repeat = 16'd1;
        cmd_valid  = 1'b1;
        @(negedge clk);
        exp_cmds++;
        chk("zero_pass", {16'd0, pass_count}, 32'd0);
        chk("zero_cmdcnt", cmd_count, 32'(exp_cmds));
        chk("held_idle_busy", {31'd0, busy}, 32'd0);
        chk("held_idle_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("held_accept_busy", {31'd0, busy}, 32'd1);
        chk("held_part", {24'd0, partial_block_cycles}, 32'd1);
        chk("zero_total_starts", 32'(start_cnt - s0), 32'd0);
        @(negedge clk);
        chk("held_start", {31'd0, start}, 32'd1);
        wait_done(READ_DELAY + 50, "held_done");
        @(negedge clk);
        exp_cmds++;
        chk("held_pass", {16'd0, pass_count}, 32'd1);

        // Reset while waiting on the reader
        issue(32'd4096, 16'd2);
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_start", {31'd0, start}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_pass", {16'd0, pass_count}, 32'd0);
        chk("mid_rst_cmdcnt", cmd_count, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        exp_cmds = 0;
        s0 = start_cnt;
        repeat (5) @(negedge clk);
        chk("post_rst_no_start", 32'(start_cnt - s0), 32'd0);
        run_one(32'd65, 32'd0, 8'd2, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
